// File: rtl/src_mem_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : src_mem_controller_if
// Description : Sequencer strobes and shared data buses of the SRC memory
//               interface unit. The conflict signal exists only when
//               SRC_MEMC_CONFLICT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface src_mem_controller_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) ();
    wire  [DATA_W-1:0] cpu_bus;
    wire  [DATA_W-1:0] mem_bus;
    logic              ma_in;
    logic              md_in;
    logic              md_out;
    logic              read;
    logic              enable;
    logic [ADDR_W-1:0] address;
`ifdef SRC_MEMC_CONFLICT_EN
    logic              conflict;

    modport slave (
        inout  cpu_bus, mem_bus,
        input  ma_in, md_in, md_out, read, enable,
        output address, conflict
    );

    modport master (
        inout  cpu_bus, mem_bus,
        output ma_in, md_in, md_out, read, enable,
        input  address, conflict
    );
`else
    modport slave (
        inout  cpu_bus, mem_bus,
        input  ma_in, md_in, md_out, read, enable,
        output address
    );

    modport master (
        inout  cpu_bus, mem_bus,
        output ma_in, md_in, md_out, read, enable,
        input  address
    );
`endif
endinterface
`default_nettype wire

// File: rtl/src_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : src_mem_controller
// Description : SRC memory interface unit holding MA and MD and bridging the
//               internal CPU bus to the external memory data bus. Optional
//               sticky strobe-conflict flag under SRC_MEMC_CONFLICT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module src_mem_controller #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    src_mem_controller_if.slave bus
);

    logic [ADDR_W-1:0] r_ma;
    logic [DATA_W-1:0] r_md;
    logic [DATA_W-1:0] w_md_next;
    logic [DATA_W-1:0] w_cpu_drv;
    logic              w_rd_access;
    logic              w_wr_access;
    logic              w_cpu_oe;
    logic              w_mem_oe;

    assign w_rd_access = bus.enable & bus.read;
    assign w_wr_access = bus.enable & ~bus.read;

    // Drivers are gated by rst_n so both buses float during reset whatever the strobes say.
    assign w_cpu_oe = rst_n & bus.md_out;
    assign w_mem_oe = rst_n & w_wr_access;

    assign w_cpu_drv   = w_rd_access ? bus.mem_bus : r_md;
    assign bus.cpu_bus = w_cpu_oe ? w_cpu_drv : {DATA_W{1'bz}};
    assign bus.mem_bus = w_mem_oe ? r_md      : {DATA_W{1'bz}};
    assign bus.address = r_ma;

    // A memory read outranks a CPU-bus load; md_in with md_out would reload MD from itself.
    always_comb begin
        w_md_next = r_md;
        if (w_rd_access) begin
            w_md_next = bus.mem_bus;
        end else if (bus.md_in && !bus.md_out) begin
            w_md_next = bus.cpu_bus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ma <= '0;
            r_md <= '0;
        end else begin
            if (bus.ma_in) begin
                r_ma <= bus.cpu_bus[ADDR_W-1:0];
            end
            r_md <= w_md_next;
        end
    end

`ifdef SRC_MEMC_CONFLICT_EN
    logic r_conflict;
    logic w_conflict_set;

    assign w_conflict_set = (bus.md_in & bus.md_out) |
                            (bus.ma_in & bus.md_out) |
                            (w_wr_access & bus.md_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict <= 1'b0;
        end else if (w_conflict_set) begin
            r_conflict <= 1'b1;
        end
    end

    assign bus.conflict = r_conflict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_src_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_src_mem_controller
// Description : Directed scoreboard bench for src_mem_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_src_mem_controller;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam logic [DATA_W-1:0] c_probe = 32'hA5C3_0F96;

    localparam int K_ADDR = 0;
    localparam int K_CPU  = 1;
    localparam int K_MEM  = 2;
    localparam int K_CPUZ = 3;
    localparam int K_MEMZ = 4;
    localparam int K_CONF = 5;

    typedef struct {
        int                kind;
        logic [DATA_W-1:0] exp;
        string             name;
    } exp_t;

    logic clk;
    logic rst_n;

    logic              tb_cpu_oe;
    logic [DATA_W-1:0] tb_cpu_drv;
    logic              tb_mem_oe;
    logic [DATA_W-1:0] tb_mem_drv;
    logic              pr_cpu_oe;
    logic              pr_mem_oe;
    logic [DATA_W-1:0] pr_val;

    int checks;
    int errors;
    exp_t sb[$];

    src_mem_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    src_mem_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    assign bif.cpu_bus = tb_cpu_oe ? tb_cpu_drv : (pr_cpu_oe ? pr_val : {DATA_W{1'bz}});
    assign bif.mem_bus = tb_mem_oe ? tb_mem_drv : (pr_mem_oe ? pr_val : {DATA_W{1'bz}});

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required normal completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input int kind, input logic [DATA_W-1:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic report(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // A released bus must follow a bench probe pattern and its complement.
    task automatic check_released(input bit is_cpu, input string name);
        logic [DATA_W-1:0] a0;
        logic [DATA_W-1:0] a1;
        pr_val = c_probe;
        if (is_cpu) pr_cpu_oe = 1'b1; else pr_mem_oe = 1'b1;
        #1;
        a0 = is_cpu ? bif.cpu_bus : bif.mem_bus;
        pr_val = ~c_probe;
        #1;
        a1 = is_cpu ? bif.cpu_bus : bif.mem_bus;
        pr_cpu_oe = 1'b0;
        pr_mem_oe = 1'b0;
        checks++;
        if (a0 !== c_probe || a1 !== ~c_probe) begin
            errors++;
            $display("FAIL %s: got probe readback %h/%h, required released bus (%h/%h)",
                     name, a0, a1, c_probe, ~c_probe);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.kind)
                    K_ADDR: report(e.name, {{(DATA_W-ADDR_W){1'b0}}, bif.address}, e.exp);
                    K_CPU:  report(e.name, bif.cpu_bus, e.exp);
                    K_MEM:  report(e.name, bif.mem_bus, e.exp);
                    K_CPUZ: check_released(1'b1, e.name);
                    K_MEMZ: check_released(1'b0, e.name);
`ifdef SRC_MEMC_CONFLICT_EN
                    K_CONF: report(e.name, {{(DATA_W-1){1'b0}}, bif.conflict}, e.exp);
`endif
                    default: ;
                endcase
            end
        end
    end

    task automatic drive(input logic ma, input logic mdi, input logic mdo,
                         input logic rd, input logic en);
        bif.ma_in  = ma;
        bif.md_in  = mdi;
        bif.md_out = mdo;
        bif.read   = rd;
        bif.enable = en;
    endtask

    task automatic bus_drv(input logic coe, input logic [DATA_W-1:0] cv,
                           input logic moe, input logic [DATA_W-1:0] mv);
        tb_cpu_oe  = coe;
        tb_cpu_drv = cv;
        tb_mem_oe  = moe;
        tb_mem_drv = mv;
    endtask

    initial begin : stimulus
        checks    = 0;
        errors    = 0;
        pr_cpu_oe = 1'b0;
        pr_mem_oe = 1'b0;
        pr_val    = '0;
        rst_n     = 1'b0;
        bus_drv(1'b0, '0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset with md_out and a write strobe asserted
        repeat (2) @(negedge clk);
        push(K_ADDR, 32'h0, "reset_addr");
        push(K_CPUZ, 32'h0, "reset_cpu_z");
        push(K_MEMZ, 32'h0, "reset_mem_z");
`ifdef SRC_MEMC_CONFLICT_EN
        push(K_CONF, 32'h0, "reset_conflict");
`endif

        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(K_CPU,  32'h0, "reset_md_readback");
        push(K_MEMZ, 32'h0, "idle_mem_z");

        // Address load ignores upper cpu_bus bits and lands one cycle later
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus_drv(1'b1, 32'h0001_2345, 1'b0, '0);
        push(K_ADDR, 32'h0, "addr_before_edge");

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus_drv(1'b1, 32'hFFFF_AAAA, 1'b0, '0);
        push(K_ADDR, 32'h0000_2345, "addr_loaded");

        @(negedge clk);
        push(K_ADDR, 32'h0000_2345, "addr_held");

        // Read: same-cycle pass-through, then MD holds the word
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        bus_drv(1'b0, '0, 1'b1, 32'hDEAD_BEEF);
        push(K_CPU,  32'hDEAD_BEEF, "read_passthru");
        push(K_ADDR, 32'h0000_2345, "read_addr");

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        bus_drv(1'b0, '0, 1'b0, '0);
        push(K_CPU,  32'hDEAD_BEEF, "read_md_held");
        push(K_MEMZ, 32'h0, "read_done_mem_z");

        // Write: load MD from cpu_bus, then drive memory
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus_drv(1'b1, 32'h0000_0EE3, 1'b0, '0);
        push(K_MEMZ, 32'h0, "md_load_mem_z");

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus_drv(1'b0, '0, 1'b0, '0);
        push(K_MEM,  32'h0000_0EE3, "write_mem");
        push(K_CPUZ, 32'h0, "write_cpu_z");

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(K_MEMZ, 32'h0, "write_end_mem_z");
        push(K_CPU,  32'h0000_0EE3, "write_md_readback");

        // Memory read outranks md_in
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        bus_drv(1'b1, 32'h2222_2222, 1'b1, 32'h1111_1111);

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus_drv(1'b0, '0, 1'b0, '0);
        push(K_CPU, 32'h1111_1111, "priority_md");

        // enable=0 with read=1: no load from memory
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bus_drv(1'b0, '0, 1'b1, 32'h5555_AAAA);
        push(K_CPUZ, 32'h0, "disabled_cpu_z");

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        bus_drv(1'b0, '0, 1'b0, '0);
        push(K_CPU, 32'h1111_1111, "disabled_no_load");

        // Reset asserted during a write releases buses at once
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(K_MEM, 32'h1111_1111, "pre_reset_write");

        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        push(K_ADDR, 32'h0, "midreset_addr");
        push(K_MEMZ, 32'h0, "midreset_mem_z");
        push(K_CPUZ, 32'h0, "midreset_cpu_z");

        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(K_CPU, 32'h0, "midreset_md_cleared");

`ifdef SRC_MEMC_CONFLICT_EN
        // md_in with md_out: flag sets and sticks, MD untouched
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        push(K_CONF, 32'h0, "conflict_before_edge");

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(K_CONF, 32'h1, "conflict_set");
        push(K_CPU,  32'h0, "conflict_md_unchanged");

        repeat (2) @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(K_CONF, 32'h1, "conflict_sticky");

        @(negedge clk);
        rst_n = 1'b0;
        push(K_CONF, 32'h0, "conflict_cleared");

        @(negedge clk);
        rst_n = 1'b1;
`endif

        repeat (2) @(negedge clk);
        #8;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/src_mem_controller.md
Name: src_mem_controller

Overview:
- Memory interface unit of the SRC CPU datapath. Holds the memory address register (MA) and the memory data register (MD).
- Bridges the shared internal CPU bus (cpu_bus) and the external memory data bus (mem_bus).
- Drives the external address.
- The CPU sequencer controls it through the strobes ma_in, md_in, md_out, read and enable.

Parameters:
- ADDR_W, 16, width of MA and of the address output; MA loads cpu_bus[ADDR_W-1:0].
- DATA_W, 32, width of cpu_bus, mem_bus and MD.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cpu_bus  inout  DATA_W  shared CPU bus; tri-stated unless md_out=1.
- mem_bus  inout  DATA_W  external memory data bus; tri-stated unless a write is in progress.
- ma_in  input  1  load MA from cpu_bus.
- md_in  input  1  load MD from cpu_bus.
- md_out  input  1  drive cpu_bus from the memory data path.
- read  input  1  1 = memory read, 0 = memory write; meaningful only while enable=1.
- enable  input  1  memory access active.
- address  output  ADDR_W  external memory address, equal to MA at all times.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - MA=0 and MD=0, so address=0.
  - cpu_bus and mem_bus are released to Z, regardless of the strobes.
  - Registers hold 0 until the first rising edge after rst_n goes high.
- MA:
  - At a rising edge with ma_in=1, MA <= cpu_bus[ADDR_W-1:0]; upper bits are ignored.
  - address changes one cycle after ma_in is sampled.
- MD load priority, evaluated at the rising edge:
  - (1) enable=1 and read=1: MD <= mem_bus.
  - (2) else md_in=1 and md_out=0: MD <= cpu_bus.
  - (3) else MD holds.
  - md_in together with md_out is ignored, so MD never reloads its own output.
- cpu_bus drive, combinational:
  - md_out=1 and enable=1 and read=1: cpu_bus = mem_bus (pass-through).
  - md_out=1 otherwise: cpu_bus = MD.
  - md_out=0: Z.
- Read timing: with ma_in applied in cycle N, read/enable/md_out asserted in cycle N+1, the CPU captures the memory word from cpu_bus at the edge ending cycle N+1. MD captures the same word at that edge.
- mem_bus drive:
  - enable=1 and read=0: mem_bus = MD (write).
  - Otherwise mem_bus = Z.
- enable=0: read is don't-care; there is no memory activity and no MD load from memory.
- There is no internal state machine. The block is single-cycle, and the strobes are level-sampled each edge.
- Reset asserted mid-access: buses release immediately, registers clear, and the access is abandoned.

Optional Feature:
- Macro SRC_MEMC_CONFLICT_EN.
- Defined: extra output port conflict (1 bit, sticky).
  - Set at a rising edge when (md_in & md_out) or (ma_in & md_out) or (enable & ~read & md_in).
  - Cleared only by rst_n=0; reset value 0.
- Undefined: no conflict port and no associated logic; behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 with md_out=1, enable=1, read=0 -> address=0, cpu_bus=Z, mem_bus=Z; after release, MD reads back 0 via md_out.
- Address load: cpu_bus=32'h0001_2345, ma_in=1 for one edge -> address=16'h2345 from the next cycle and held after ma_in drops.
- Read pass-through: memory drives mem_bus=32'hDEAD_BEEF, read=enable=md_out=1 -> cpu_bus=32'hDEAD_BEEF in the same cycle; after the edge, with enable=0 and md_out=1, cpu_bus=32'hDEAD_BEEF (from MD).
- Write: cpu_bus=32'h0000_0EE3, md_in=1 for one edge, then enable=1, read=0 -> mem_bus=32'h0000_0EE3 and cpu_bus=Z; enable=0 -> mem_bus=Z.
- Priority: enable=read=1, md_in=1, mem_bus=32'h1111_1111, cpu_bus=32'h2222_2222 -> MD=32'h1111_1111 after the edge.
- With SRC_MEMC_CONFLICT_EN: md_in=md_out=1 for one edge -> conflict=1 and stays 1 until rst_n=0; MD unchanged.
